mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_lane_mult.sv | 46 ++++
 rtl/mac_pipe.sv | 197 +++++++++++++++++++
 tb/tb_mac_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the mac_pipe dot-product engine.
//   mac_state_t      : control FSM states
//   DEF_DATA_WIDTH   : default operand width per lane
//   DEF_LANES        : default number of multiplier lanes
//   DEF_LEN_WIDTH    : default width of the vector-length input
package mac_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 4;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_lane_mult.sv
// mac_lane_mult -- one multiplier lane with its stage-1 product register.
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset, zeroes the product
//   clr          : synchronous clear, zeroes the product
//   en           : load a new product (beat accepted)
//   signed_mode  : 1 = operands are two's complement, 0 = unsigned
//   a, b         : lane operands, DATA_WIDTH bits each
//   prod         : registered 2*DATA_WIDTH-bit product
module mac_lane_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic                      signed_mode,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic [2*DATA_WIDTH-1:0]   prod
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] a_ext_p0;
  logic signed [PW-1:0] b_ext_p0;
  logic signed [PW-1:0] prod_p0;
  logic        [PW-1:0] prod_p1;

  // Operands are widened to the full product width first, so the low PW
  // bits of a same-width multiply are the exact product in either mode.
  assign a_ext_p0 = $signed({{DATA_WIDTH{signed_mode & a[DATA_WIDTH-1]}}, a});
  assign b_ext_p0 = $signed({{DATA_WIDTH{signed_mode & b[DATA_WIDTH-1]}}, b});
  assign prod_p0  = a_ext_p0 * b_ext_p0;

  // ---- stage 0 -> stage 1 ----
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod_p1 <= '0;
    end else if (en) begin
      prod_p1 <= prod_p0;
    end
  end

  assign prod = prod_p1;

endmodule

// File: rtl/mac_pipe.sv
// mac_pipe -- pipelined multi-lane multiply-accumulate (dot product).
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   Clr          : synchronous clear of the dot product in progress
//   in_valid     : a beat is present on Ain/Bin
//   in_ready     : a beat is accepted this cycle (IDLE/ACCUM, not in reset)
//   Ain, Bin     : LANES packed operands, lane 0 in the LSBs
//   len          : beats per vector (0 means 1), sampled on the first beat
//   signed_mode  : two's-complement operation, sampled on the first beat
//   sat_en       : saturate instead of wrap, sampled on the first beat
//   out_valid    : Cout holds a completed result (HOLD state)
//   out_ready    : consumer takes the result
//   Cout         : accumulated dot product
//   ovf          : an overflow occurred in the vector shown on Cout
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ACC_WIDTH  = 3 * DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   Ain,
  input  logic [LANES*DATA_WIDTH-1:0]   Bin,
  input  logic [LEN_WIDTH-1:0]          len,
  input  logic                          signed_mode,
  input  logic                          sat_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          Cout,
  output logic                          ovf
);

  localparam int PW = 2 * DATA_WIDTH;

  // Sign- or zero-extend one lane product to the accumulation width.
  function automatic logic signed [ACC_WIDTH:0] ext_prod(
    input logic [PW-1:0] p,
    input logic          sgn
  );
    return $signed({{(ACC_WIDTH + 1 - PW){sgn & p[PW-1]}}, p});
  endfunction

  // Overflow of the ACC_WIDTH+1-bit sum: sign disagreement when signed,
  // carry out of ACC_WIDTH bits when unsigned.
  function automatic logic ovf_detect(
    input logic [ACC_WIDTH:0] s,
    input logic               sgn
  );
    return sgn ? (s[ACC_WIDTH] ^ s[ACC_WIDTH-1]) : s[ACC_WIDTH];
  endfunction

  // Clamp to the range limit on overflow when saturating, otherwise wrap.
  function automatic logic [ACC_WIDTH-1:0] saturate(
    input logic [ACC_WIDTH:0] s,
    input logic               sgn,
    input logic               sat,
    input logic               ov
  );
    if (!ov || !sat) begin
      return s[ACC_WIDTH-1:0];
    end
    if (!sgn) begin
      return '1;
    end
    // The extra top bit is the true sign of the unclamped sum.
    return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                        : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
  endfunction

  mac_state_t               state_q;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     cnt_p0;
  logic [LEN_WIDTH-1:0]     cnt_inc_p0;
  logic [LEN_WIDTH-1:0]     len_eff_p0;
  logic                     mode_q;
  logic                     sat_q;
  logic                     accept_p0;
  logic                     mult_mode_p0;
  logic                     vld_p1;
  logic                     out_valid_q;
  logic [PW-1:0]            prod_p1 [LANES];
  logic signed [ACC_WIDTH:0] lane_sum_p1;
  logic signed [ACC_WIDTH:0] sum_p2;
  logic                     ovf_hit_p2;
  logic [ACC_WIDTH-1:0]     acc_nxt_p2;
  logic [ACC_WIDTH-1:0]     acc_p2;
  logic                     ovf_p2;

  assign in_ready   = ~rst & ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
  // A beat coinciding with Clr is dropped.
  assign accept_p0  = in_valid & in_ready & ~Clr;
  assign len_eff_p0 = (len == '0) ? LEN_WIDTH'(1) : len;
  assign cnt_inc_p0 = cnt_p0 + LEN_WIDTH'(1);
  // The first beat is multiplied with the mode being latched on that edge.
  assign mult_mode_p0 = (state_q == ST_IDLE) ? signed_mode : mode_q;

  // ---- stage 0 -> stage 1 ----
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane_mult #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
      .clk         (clk),
      .rst         (rst),
      .clr         (Clr),
      .en          (accept_p0),
      .signed_mode (mult_mode_p0),
      .a           (Ain[g*DATA_WIDTH +: DATA_WIDTH]),
      .b           (Bin[g*DATA_WIDTH +: DATA_WIDTH]),
      .prod        (prod_p1[g])
    );
  end

  // ---- stage 1 -> stage 2 ----
  always_comb begin
    lane_sum_p1 = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum_p1 = lane_sum_p1 + ext_prod(prod_p1[l], mode_q);
    end
  end

  assign sum_p2     = $signed({mode_q & acc_p2[ACC_WIDTH-1], acc_p2}) + lane_sum_p1;
  assign ovf_hit_p2 = ovf_detect(sum_p2, mode_q);
  assign acc_nxt_p2 = saturate(sum_p2, mode_q, sat_q, ovf_hit_p2);

  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_p0      <= '0;
      mode_q      <= 1'b0;
      sat_q       <= 1'b0;
      vld_p1      <= 1'b0;
      acc_p2      <= '0;
      ovf_p2      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;

      // Once a saturating vector has clamped, the clamp is held.
      if (vld_p1 && !(sat_q && ovf_p2)) begin
        acc_p2 <= acc_nxt_p2;
        if (ovf_hit_p2) begin
          ovf_p2 <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept_p0) begin
            len_q   <= len_eff_p0;
            mode_q  <= signed_mode;
            sat_q   <= sat_en;
            cnt_p0  <= LEN_WIDTH'(1);
            acc_p2  <= '0;
            ovf_p2  <= 1'b0;
            state_q <= (len_eff_p0 == LEN_WIDTH'(1)) ? ST_DRAIN : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept_p0) begin
            cnt_p0 <= cnt_inc_p0;
            if (cnt_inc_p0 == len_q) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last product lands in the accumulator on this edge.
          state_q     <= ST_HOLD;
          out_valid_q <= 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            cnt_p0      <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign Cout      = acc_p2;
  assign ovf       = ovf_p2;

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe -- directed self-checking bench for mac_pipe (default parameters).
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        Clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Ain;
  logic [31:0] Bin;
  logic [7:0]  len;
  logic        signed_mode;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] Cout;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  mac_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .Clr         (Clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Ain         (Ain),
    .Bin         (Bin),
    .len         (len),
    .signed_mode (signed_mode),
    .sat_en      (sat_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Cout        (Cout),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Back-to-back beats; returns at the falling edge after the last acceptance.
  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input int n,
                         input logic [7:0] l, input logic sm, input logic se);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      Ain         = a;
      Bin         = b;
      len         = l;
      signed_mode = sm;
      sat_en      = se;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lim);
    int k = 0;
    while (out_valid !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy_in_hold"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_idle"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; Clr = 1'b0; in_valid = 1'b0; Ain = '0; Bin = '0; len = '0;
    signed_mode = 1'b0; sat_en = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);

    // Unsigned len=2: 2*(5+12+21+32) = 140, latency and hold behaviour
    run_vec(32'h04030201, 32'h08070605, 2, 8'd2, 1'b0, 1'b0);
    chk("lat_drain_vld", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_hold_vld", 32'(out_valid), 32'd1);
    chk("u2_cout", 32'(Cout), 32'd140);
    chk("u2_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_cout", 32'(Cout), 32'd140);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    release_out("u2");

    // Signed, len=0 treated as 1: -1*-2 + 2*3 + -3*4 + 4*-5 = -24
    run_vec(32'h04FD02FF, 32'hFB0403FE, 1, 8'd0, 1'b1, 1'b0);
    wait_out("s1_wait", 4);
    chk("s1_cout", 32'(Cout), 32'h00FFFFE8);
    chk("s1_ovf", 32'(ovf), 32'd0);
    release_out("s1");

    // Signed saturating: 128 beats * 65536 = 2^23 exceeds signed max
    run_vec(32'h80808080, 32'h80808080, 128, 8'd128, 1'b1, 1'b1);
    wait_out("ssat_wait", 4);
    chk("ssat_cout", 32'(Cout), 32'h007FFFFF);
    chk("ssat_ovf", 32'(ovf), 32'd1);
    release_out("ssat");

    // Signed wrapping
    run_vec(32'h80808080, 32'h80808080, 128, 8'd128, 1'b1, 1'b0);
    wait_out("swrap_wait", 4);
    chk("swrap_cout", 32'(Cout), 32'h00800000);
    chk("swrap_ovf", 32'(ovf), 32'd1);
    release_out("swrap");

    // Unsigned saturating: 65 * 260100 = 16906500 > 2^24-1
    run_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 65, 8'd65, 1'b0, 1'b1);
    wait_out("usat_wait", 4);
    chk("usat_cout", 32'(Cout), 32'h00FFFFFF);
    chk("usat_ovf", 32'(ovf), 32'd1);
    release_out("usat");

    // Unsigned wrapping: 16906500 - 16777216 = 129284
    run_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 65, 8'd65, 1'b0, 1'b0);
    wait_out("uwrap_wait", 4);
    chk("uwrap_cout", 32'(Cout), 32'h0001F904);
    chk("uwrap_ovf", 32'(ovf), 32'd1);
    release_out("uwrap");

    // Clr after beat 3 of len=8, with a beat offered alongside Clr
    run_vec(32'h01010101, 32'h01010101, 3, 8'd8, 1'b0, 1'b0);
    in_valid = 1'b1;
    Clr      = 1'b1;
    @(negedge clk);
    Clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_vld", 32'(out_valid), 32'd0);
    chk("clr_cout", 32'(Cout), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("clr_no_vld", 32'(out_valid), 32'd0);
    run_vec(32'h01010101, 32'h02020202, 1, 8'd1, 1'b0, 1'b0);
    wait_out("clr_next_wait", 4);
    chk("clr_next_cout", 32'(Cout), 32'd8);
    release_out("clr_next");

    // rst mid-vector
    run_vec(32'h01010101, 32'h02020202, 2, 8'd4, 1'b0, 1'b0);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_cout", 32'(Cout), 32'd0);
    chk("rstmid_vld", 32'(out_valid), 32'd0);
    chk("rstmid_rdy", 32'(in_ready), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstmid_rel_rdy", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rstmid_no_vld", 32'(out_valid), 32'd0);

    // rst during HOLD: 4 lanes of 1*3 = 12
    run_vec(32'h01010101, 32'h03030303, 1, 8'd1, 1'b0, 1'b0);
    wait_out("rsthold_wait", 4);
    chk("rsthold_cout_pre", 32'(Cout), 32'd12);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rsthold_cout", 32'(Cout), 32'd0);
    chk("rsthold_vld", 32'(out_valid), 32'd0);
    chk("rsthold_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    #1;
    chk("rsthold_rel_rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rsthold_no_vld", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
